// File: rtl/msf_display_scheduler.sv
// Steps the snapshotted MSF time (HH:MM:SS BCD) digit by digit onto one seven-segment display.
// Latency: registered outputs, first digit PAUSE_CYCLES edges after reset; no backpressure (free-running).
// Optional MSF_DISP_ZERO_BLANK_EN blanks a zero hours-tens digit.
module msf_display_scheduler #(
    parameter int DWELL_CYCLES = 1000,
    parameter int GAP_CYCLES   = 200,
    parameter int PAUSE_CYCLES = 3000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       time_valid_i,
    input  logic [7:0] hours_i,
    input  logic [7:0] minutes_i,
    input  logic [7:0] seconds_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [2:0] digit_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_SHOW   = 2'd1,
        ST_GAP    = 2'd2,
        ST_NOLOCK = 2'd3
    } state_t;

    localparam logic [15:0] DWELL_END = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] GAP_END   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] PAUSE_END = 16'(PAUSE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  digit_q, digit_d;
    logic [23:0] snap_q, snap_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        busy_q, busy_d;
    logic [3:0]  nib;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        digit_d = digit_q;
        snap_d  = snap_q;
        case (state_q)
            ST_PAUSE: begin
                if (cnt_q == PAUSE_END) begin
                    cnt_d = 16'd0;
                    if (time_valid_i) begin
                        snap_d  = {hours_i, minutes_i, seconds_i};
                        digit_d = 3'd0;
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_NOLOCK;
                    end
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_END) begin
                    cnt_d   = 16'd0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d = 16'd0;
                    if (digit_q < 3'd5) begin
                        digit_d = digit_q + 3'd1;
                        state_d = ST_SHOW;
                    end else begin
                        digit_d = 3'd0;
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_NOLOCK: begin
                if (cnt_q == DWELL_END) begin
                    cnt_d   = 16'd0;
                    digit_d = 3'd0;
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                digit_d = 3'd0;
                state_d = ST_PAUSE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the entry edge.
    always_comb begin
        case (digit_d)
            3'd0:    nib = snap_d[23:20];
            3'd1:    nib = snap_d[19:16];
            3'd2:    nib = snap_d[15:12];
            3'd3:    nib = snap_d[11:8];
            3'd4:    nib = snap_d[7:4];
            3'd5:    nib = snap_d[3:0];
            default: nib = 4'd0;
        endcase
    end

    always_comb begin
        seg_d  = 7'h00;
        dp_d   = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            ST_SHOW: begin
                busy_d = 1'b1;
                if (nib > 4'd9) begin
                    dp_d = 1'b1;
                end else begin
                    seg_d = bcd_to_seg(nib);
                    dp_d  = (digit_d == 3'd1) || (digit_d == 3'd3);
`ifdef MSF_DISP_ZERO_BLANK_EN
                    if (digit_d == 3'd0 && nib == 4'd0) begin
                        seg_d = 7'h00;
                    end
`endif
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
            end
            ST_NOLOCK: begin
                seg_d  = 7'h40;
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_PAUSE;
            cnt_q   <= 16'd0;
            digit_q <= 3'd0;
            snap_q  <= 24'd0;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign digit_o = digit_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_msf_display_scheduler.sv
// Bench for msf_display_scheduler: per-cycle comparison against a queue-based expected-output model.
module tb_msf_display_scheduler;

    localparam int DW = 4;
    localparam int GP = 2;
    localparam int PS = 3;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [2:0] dig;
        logic       busy;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       time_valid_i = 1'b0;
    logic [7:0] hours_i = 8'h00;
    logic [7:0] minutes_i = 8'h00;
    logic [7:0] seconds_i = 8'h00;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [2:0] digit_o;
    logic       busy_o;

    int vec  = 0;
    int miss = 0;
    exp_t exp_q[$];
    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    msf_display_scheduler #(
        .DWELL_CYCLES(DW),
        .GAP_CYCLES  (GP),
        .PAUSE_CYCLES(PS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .time_valid_i(time_valid_i),
        .hours_i     (hours_i),
        .minutes_i   (minutes_i),
        .seconds_i   (seconds_i),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .digit_o     (digit_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outputs after each edge; an empty queue marks a pause-exit edge.
    task automatic model_reset();
        exp_t z;
        z = '0;
        exp_q.delete();
        repeat (PS - 1) exp_q.push_back(z);
    endtask

    task automatic model_edge(output exp_t e);
        logic [23:0] t;
        logic [3:0]  nib;
        exp_t        x;
        exp_t        z;
        z = '0;
        if (exp_q.size() == 0) begin
            if (time_valid_i) begin
                t = {hours_i, minutes_i, seconds_i};
                for (int d = 0; d < 6; d++) begin
                    nib    = t[23-4*d -: 4];
                    x.busy = 1'b1;
                    x.dig  = 3'(d);
                    if (nib > 4'd9) begin
                        x.seg = 7'h00;
                        x.dp  = 1'b1;
                    end else begin
                        x.seg = seg_tab[int'(nib)];
                        x.dp  = (d == 1) || (d == 3);
`ifdef MSF_DISP_ZERO_BLANK_EN
                        if (d == 0 && nib == 4'd0) x.seg = 7'h00;
`endif
                    end
                    repeat (DW) exp_q.push_back(x);
                    x.seg = 7'h00;
                    x.dp  = 1'b0;
                    repeat (GP) exp_q.push_back(x);
                end
            end else begin
                x = '{seg: 7'h40, dp: 1'b0, dig: 3'd0, busy: 1'b1};
                repeat (DW) exp_q.push_back(x);
            end
            repeat (PS) exp_q.push_back(z);
        end
        e = exp_q.pop_front();
    endtask

    task automatic run_cycle(output exp_t e);
        @(posedge clk_i);
        model_edge(e);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic set_time(input logic v, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        time_valid_i = v;
        hours_i      = h;
        minutes_i    = m;
        seconds_i    = s;
    endtask

    task automatic test_reset();
        set_time(1'b1, 8'h12, 8'h34, 8'h56);
        rst_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== 12'h000) begin
                miss++;
                $display("FAIL reset_state: seg=%h dp=%b dig=%0d busy=%b, required all zero",
                         seg_o, dp_o, digit_o, busy_o);
            end
        end
    endtask

    task automatic test_valid_sequence();
        exp_t e;
        do_reset();
        set_time(1'b1, 8'h12, 8'h34, 8'h56);
        for (int c = 1; c <= 2 * 39; c++) begin
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL valid_seq cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
            if (c == PS) begin
                vec++;
                if (seg_o !== 7'h06) begin
                    miss++;
                    $display("FAIL first_digit: seg=%h, required 06", seg_o);
                end
            end
        end
    endtask

    task automatic test_nolock();
        exp_t e;
        do_reset();
        set_time(1'b0, 8'h12, 8'h34, 8'h56);
        for (int c = 1; c <= 4 * 7; c++) begin
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL nolock cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        do_reset();
        set_time(1'b1, 8'h12, 8'h34, 8'h56);
        for (int c = 1; c <= 100; c++) begin
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL snapshot cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
            if (c == 16) set_time(1'b1, 8'h23, 8'h59, 8'h59);
            if (c == 18) time_valid_i = 1'b0;
            if (c == 30) time_valid_i = 1'b1;
        end
    endtask

    task automatic test_bad_nibble();
        exp_t e;
        do_reset();
        set_time(1'b1, 8'h12, 8'h3A, 8'h56);
        for (int c = 1; c <= 39; c++) begin
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL bad_nibble cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        set_time(1'b1, 8'h12, 8'h34, 8'h56);
        repeat (28) run_cycle(e);
        vec++;
        if (digit_o !== 3'd4 || seg_o !== 7'h6D) begin
            miss++;
            $display("FAIL pre_reset_digit4: dig=%0d seg=%h, required dig=4 seg=6d", digit_o, seg_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vec++;
        if ({seg_o, dp_o, digit_o, busy_o} !== 12'h000) begin
            miss++;
            $display("FAIL async_reset: seg=%h dp=%b dig=%0d busy=%b, required all zero",
                     seg_o, dp_o, digit_o, busy_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        for (int c = 1; c <= 20; c++) begin
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL post_reset cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
        end
    endtask

    task automatic test_zero_blank();
        exp_t e;
        logic [6:0] want0;
`ifdef MSF_DISP_ZERO_BLANK_EN
        want0 = 7'h00;
`else
        want0 = 7'h3F;
`endif
        do_reset();
        set_time(1'b1, 8'h09, 8'h00, 8'h00);
        for (int c = 1; c <= 39; c++) begin
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL zero_blank cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
            if (c == PS + 1) begin
                vec++;
                if (seg_o !== want0) begin
                    miss++;
                    $display("FAIL hours_tens_zero: seg=%h, required %h", seg_o, want0);
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        do_reset();
        for (int c = 1; c <= 3000; c++) begin
            time_valid_i = ($urandom_range(0, 3) != 0);
            hours_i      = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                           {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            minutes_i    = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            seconds_i    = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                           {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            run_cycle(e);
            vec++;
            if ({seg_o, dp_o, digit_o, busy_o} !== e) begin
                miss++;
                $display("FAIL random cyc %0d: got seg=%h dp=%b dig=%0d busy=%b, exp seg=%h dp=%b dig=%0d busy=%b",
                         c, seg_o, dp_o, digit_o, busy_o, e.seg, e.dp, e.dig, e.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_sequence();
        test_nolock();
        test_snapshot();
        test_bad_nibble();
        test_async_reset();
        test_zero_blank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
